// File: rtl/mfp_ahb_interconnect_if.sv
// AHB-lite bundle between the core bus port, the interconnect and its slaves.
// master: core plus slave responses (everything the interconnect samples); slave: interconnect view.
interface mfp_ahb_interconnect_if #(
    parameter int NSLAVES = 4
);
    logic [31:0]           HADDR;
    logic [1:0]            HTRANS;
    logic [NSLAVES-1:0]    HSEL;
    logic [NSLAVES-1:0]    HREADYOUT_S;
    logic [NSLAVES-1:0]    HRESP_S;
    logic [32*NSLAVES-1:0] HRDATA_S;
    logic                  HREADY;
    logic                  HRESP;
    logic [31:0]           HRDATA;
    logic                  ERR_VALID;
    logic [31:0]           ERR_ADDR;
    logic                  ERR_CLR;

    modport master (
        output HADDR, HTRANS, HREADYOUT_S, HRESP_S, HRDATA_S, ERR_CLR,
        input  HSEL, HREADY, HRESP, HRDATA, ERR_VALID, ERR_ADDR
    );

    modport slave (
        input  HADDR, HTRANS, HREADYOUT_S, HRESP_S, HRDATA_S, ERR_CLR,
        output HSEL, HREADY, HRESP, HRDATA, ERR_VALID, ERR_ADDR
    );
endinterface

// File: rtl/mfp_ahb_interconnect.sv
// AHB-lite single-master interconnect: address decode, data-phase response mux, default slave.
// Define MFP_AHB_IC_ERRLOG_EN to add the sticky error-address capture register.
module mfp_ahb_interconnect #(
    parameter int                    NSLAVES = 4,
    parameter logic [32*NSLAVES-1:0] SL_BASE = {32'h1F70_0000, 32'h1F80_0000,
                                                32'h0000_0000, 32'h1FC0_0000},
    parameter logic [32*NSLAVES-1:0] SL_MASK = {32'h1FF0_0000, 32'h1FC0_0000,
                                                32'h1000_0000, 32'h1FC0_0000}
) (
    input  logic                  HCLK_i,
    input  logic                  HRESET_i,
    mfp_ahb_interconnect_if.slave ahb_io
);
    // state  | meaning
    // D_IDLE | default slave answers OKAY with no wait
    // D_ERR1 | first ERROR cycle, HREADY low
    // D_ERR2 | final ERROR cycle, HREADY high
    typedef enum logic [1:0] {D_IDLE, D_ERR1, D_ERR2} dflt_state_e;

    logic [NSLAVES-1:0] hsel;
    logic               hit_any;
    logic               start_err;
    logic               hready;
    logic               hresp;
    logic [31:0]        hrdata;
    logic [NSLAVES:0]   sel_q;
    logic [NSLAVES:0]   sel_d;
    dflt_state_e        dstate_q;
    logic               dready_q;
    logic               dresp_q;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        hsel = '0;
        for (int i = NSLAVES - 1; i >= 0; i--) begin
            if ((ahb_io.HADDR & SL_MASK[32*i +: 32]) == SL_BASE[32*i +: 32]) begin
                hsel    = '0;
                hsel[i] = 1'b1;
            end
        end
    end

    assign hit_any   = |hsel;
    assign start_err = hready & ~hit_any & ahb_io.HTRANS[1];
    assign sel_d     = hready ? {~hit_any, hsel} : sel_q;

    always_comb begin
        hready = dready_q;
        hresp  = dresp_q;
        hrdata = '0;
        for (int i = 0; i < NSLAVES; i++) begin
            if (sel_q[i]) begin
                hready = ahb_io.HREADYOUT_S[i];
                hresp  = ahb_io.HRESP_S[i];
                hrdata = ahb_io.HRDATA_S[32*i +: 32];
            end
        end
    end

    always_ff @(posedge HCLK_i or posedge HRESET_i) begin
        if (HRESET_i) begin
            sel_q <= '0;
        end else begin
            sel_q <= sel_d;
        end
    end

    always_ff @(posedge HCLK_i or posedge HRESET_i) begin
        if (HRESET_i) begin
            dstate_q <= D_IDLE;
            dready_q <= 1'b1;
            dresp_q  <= 1'b0;
        end else begin
            case (dstate_q)
                D_IDLE: begin
                    if (start_err) begin
                        dstate_q <= D_ERR1;
                        dready_q <= 1'b0;
                        dresp_q  <= 1'b1;
                    end
                end
                D_ERR1: begin
                    dstate_q <= D_ERR2;
                    dready_q <= 1'b1;
                    dresp_q  <= 1'b1;
                end
                D_ERR2: begin
                    if (start_err) begin
                        dstate_q <= D_ERR1;
                        dready_q <= 1'b0;
                        dresp_q  <= 1'b1;
                    end else begin
                        dstate_q <= D_IDLE;
                        dready_q <= 1'b1;
                        dresp_q  <= 1'b0;
                    end
                end
                default: begin
                    dstate_q <= D_IDLE;
                    dready_q <= 1'b1;
                    dresp_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ahb_io.HSEL   = hsel;
    assign ahb_io.HREADY = hready;
    assign ahb_io.HRESP  = hresp;
    assign ahb_io.HRDATA = hrdata;

`ifdef MFP_AHB_IC_ERRLOG_EN
    logic [31:0] addr_q;
    logic [31:0] addr_d;
    logic        err_valid_q;
    logic        err_valid_d;
    logic [31:0] err_addr_q;
    logic [31:0] err_addr_d;
    logic        err_set;

    // A fresh error in the clear cycle re-arms the flag with the new address.
    assign addr_d  = hready ? ahb_io.HADDR : addr_q;
    assign err_set = hready & hresp & (~err_valid_q | ahb_io.ERR_CLR);

    always_comb begin
        err_valid_d = err_valid_q;
        err_addr_d  = err_addr_q;
        if (err_set) begin
            err_valid_d = 1'b1;
            err_addr_d  = addr_q;
        end else if (ahb_io.ERR_CLR) begin
            err_valid_d = 1'b0;
        end
    end

    always_ff @(posedge HCLK_i or posedge HRESET_i) begin
        if (HRESET_i) begin
            addr_q      <= '0;
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            addr_q      <= addr_d;
            err_valid_q <= err_valid_d;
            err_addr_q  <= err_addr_d;
        end
    end

    assign ahb_io.ERR_VALID = err_valid_q;
    assign ahb_io.ERR_ADDR  = err_addr_q;
`else
    logic unused_err_clr;
    assign unused_err_clr   = ahb_io.ERR_CLR;
    assign ahb_io.ERR_VALID = 1'b0;
    assign ahb_io.ERR_ADDR  = '0;
`endif
endmodule

// File: tb/tb_mfp_ahb_interconnect.sv
// Bench for mfp_ahb_interconnect: directed scenarios then random traffic vs. a transaction-level model.
module tb_mfp_ahb_interconnect;
    localparam int N = 4;
    localparam logic [1:0] NS = 2'b10;
    localparam logic [1:0] ID = 2'b00;
    localparam logic [31:0] BASE [N] = '{32'h1FC0_0000, 32'h0000_0000, 32'h1F80_0000, 32'h1F70_0000};
    localparam logic [31:0] MASK [N] = '{32'h1FC0_0000, 32'h1000_0000, 32'h1FC0_0000, 32'h1FF0_0000};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mfp_ahb_interconnect_if #(.NSLAVES(N)) bus ();
    mfp_ahb_interconnect #(.NSLAVES(N)) dut (.HCLK_i(clk), .HRESET_i(rst), .ahb_io(bus));

    int total = 0;
    int bad   = 0;

    // model: who owns the data phase (-1 none, N default slave) and error-response progress
    int          owner;
    int          derr;
    logic        ev;
    logic [31:0] ea;
    logic [31:0] last_addr;
    logic [31:0] sdata [N];

    logic [N-1:0] s_hsel;
    logic         s_hready, s_hresp, s_ev;
    logic [31:0]  s_hrdata, s_ea;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < N; i++)
            if ((a & MASK[i]) == BASE[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        owner = -1; derr = 0; ev = 1'b0; ea = '0; last_addr = '0;
    endtask

    task automatic step(input logic [31:0] a, input logic [1:0] t, input logic [N-1:0] rdy,
                        input logic [N-1:0] rsp, input logic clr);
        int           hit;
        logic [N-1:0] hs;
        logic         er, ep;
        logic [31:0]  ed;
        @(negedge clk);
        bus.HADDR = a; bus.HTRANS = t; bus.HREADYOUT_S = rdy; bus.HRESP_S = rsp; bus.ERR_CLR = clr;
        for (int i = 0; i < N; i++) bus.HRDATA_S[32*i +: 32] = sdata[i];
        hit = decode(a);
        hs  = '0;
        if (hit >= 0) hs[hit] = 1'b1;
        if (owner >= 0 && owner < N) begin
            er = rdy[owner]; ep = rsp[owner]; ed = sdata[owner];
        end else begin
            er = (derr != 1); ep = (derr != 0); ed = '0;
        end
        #1;
        s_hsel = bus.HSEL; s_hready = bus.HREADY; s_hresp = bus.HRESP; s_hrdata = bus.HRDATA;
        s_ev = bus.ERR_VALID; s_ea = bus.ERR_ADDR;
        chk("hsel",   32'(s_hsel),   32'(hs));
        chk("hready", 32'(s_hready), 32'(er));
        chk("hresp",  32'(s_hresp),  32'(ep));
        chk("hrdata", s_hrdata,      ed);
        chk("errv",   32'(s_ev),     32'(ev));
        chk("erra",   s_ea,          ea);
        @(posedge clk);
`ifdef MFP_AHB_IC_ERRLOG_EN
        if (er && ep && (!ev || clr)) begin
            ev = 1'b1; ea = last_addr;
        end else if (clr) begin
            ev = 1'b0;
        end
`endif
        if (er) begin
            last_addr = a;
            owner     = (hit < 0) ? N : hit;
            derr      = (hit < 0 && t[1]) ? 1 : 0;
        end else if (derr == 1) begin
            derr = 2;
        end
    endtask

    task automatic err_seq(input logic [31:0] a, input logic clr_last);
        step(a, NS, '1, '0, 1'b0);
        step(32'h0, ID, '1, '0, 1'b0);
        step(32'h0, ID, '1, '0, clr_last);
        step(32'h0, ID, '1, '0, 1'b0);
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  t;
        logic [N-1:0] r, p;
        logic        c;
        int          k;

        sdata[0] = 32'hDEAD_BEEF; sdata[1] = 32'h1111_2222;
        sdata[2] = 32'h3333_4444; sdata[3] = 32'h5555_6666;
        bus.HADDR = 32'h1F80_0000; bus.HTRANS = ID; bus.HREADYOUT_S = '1; bus.HRESP_S = '0;
        bus.HRDATA_S = '0; bus.ERR_CLR = 1'b0;
        model_reset();

        #12;
        chk("rst_hsel",   32'(bus.HSEL),      32'h4);
        chk("rst_hready", 32'(bus.HREADY),    32'h1);
        chk("rst_hresp",  32'(bus.HRESP),     32'h0);
        chk("rst_hrdata", bus.HRDATA,         32'h0);
        chk("rst_errv",   32'(bus.ERR_VALID), 32'h0);
        chk("rst_erra",   bus.ERR_ADDR,       32'h0);
        bus.HADDR = 32'h1FC0_0010;
        #1 chk("rst_hsel_follow", 32'(bus.HSEL), 32'h1);
        @(posedge clk);
        #1 rst = 1'b0;

        // slave0 read
        step(32'h1FC0_0010, NS, '1, '0, 1'b0);
        chk("t1_hsel", 32'(s_hsel), 32'h1);
        step(32'h0000_0100, NS, '1, '0, 1'b0);
        chk("t1_rdata", s_hrdata, 32'hDEAD_BEEF);
        chk("t1_ready", 32'(s_hready), 32'h1);
        chk("t1_resp",  32'(s_hresp),  32'h0);
        chk("t2_hsel",  32'(s_hsel),   32'h2);

        // slave1 stalls for three cycles while the next address waits
        for (int i = 0; i < 3; i++) begin
            step(32'h1F80_0000, NS, 4'b1101, '0, 1'b0);
            chk("t2_stall", 32'(s_hready), 32'h0);
            chk("t2_next_hsel", 32'(s_hsel), 32'h4);
        end
        step(32'h1F80_0000, NS, '1, '0, 1'b0);
        chk("t2_ready", 32'(s_hready), 32'h1);
        chk("t2_rdata", s_hrdata, 32'h1111_2222);
        step(32'h1E00_0000, NS, '1, '0, 1'b0);
        chk("t2_s2_rdata", s_hrdata, 32'h3333_4444);
        chk("t3_hsel", 32'(s_hsel), 32'h0);

        // unmapped NONSEQ then IDLE to the same address
        step(32'h1E00_0000, ID, '1, '0, 1'b0);
        chk("t3_e1_ready", 32'(s_hready), 32'h0);
        chk("t3_e1_resp",  32'(s_hresp),  32'h1);
        chk("t3_e1_rdata", s_hrdata,      32'h0);
        step(32'h1E00_0000, ID, '1, '0, 1'b0);
        chk("t3_e2_ready", 32'(s_hready), 32'h1);
        chk("t3_e2_resp",  32'(s_hresp),  32'h1);
        for (int i = 0; i < 2; i++) begin
            step(32'h1E00_0000, ID, '1, '0, 1'b0);
            chk("t3_idle_ready", 32'(s_hready), 32'h1);
            chk("t3_idle_resp",  32'(s_hresp),  32'h0);
        end

        // back-to-back unmapped NONSEQ
        step(32'h1E00_0010, NS, '1, '0, 1'b0);
        step(32'h1E00_0020, NS, '1, '0, 1'b0);
        chk("t4_c0_ready", 32'(s_hready), 32'h0);
        step(32'h1E00_0020, NS, '1, '0, 1'b0);
        chk("t4_c1_ready", 32'(s_hready), 32'h1);
        chk("t4_c1_resp",  32'(s_hresp),  32'h1);
        step(32'h0, ID, '1, '0, 1'b0);
        chk("t4_c2_ready", 32'(s_hready), 32'h0);
        chk("t4_c2_rdata", s_hrdata,      32'h0);
        step(32'h0, ID, '1, '0, 1'b0);
        chk("t4_c3_ready", 32'(s_hready), 32'h1);
        chk("t4_c3_resp",  32'(s_hresp),  32'h1);
        chk("t4_c3_rdata", s_hrdata,      32'h0);
        step(32'h0, ID, '1, '0, 1'b0);
        chk("t4_done_resp", 32'(s_hresp), 32'h0);

        // error capture
        step(32'h0, ID, '1, '0, 1'b1);
        err_seq(32'h1E00_0004, 1'b0);
`ifdef MFP_AHB_IC_ERRLOG_EN
        chk("t5_valid", 32'(s_ev), 32'h1);
        chk("t5_addr",  s_ea,      32'h1E00_0004);
`else
        chk("t5_valid_off", 32'(s_ev), 32'h0);
        chk("t5_addr_off",  s_ea,      32'h0);
`endif
        err_seq(32'h1E00_0008, 1'b0);
`ifdef MFP_AHB_IC_ERRLOG_EN
        chk("t5_sticky", s_ea, 32'h1E00_0004);
`endif
        step(32'h0, ID, '1, '0, 1'b1);
        step(32'h0, ID, '1, '0, 1'b0);
        chk("t5_cleared", 32'(s_ev), 32'h0);
        err_seq(32'h1E00_0030, 1'b0);
        err_seq(32'h1E00_0040, 1'b1);
`ifdef MFP_AHB_IC_ERRLOG_EN
        chk("t5_setwins_v", 32'(s_ev), 32'h1);
        chk("t5_setwins_a", s_ea,      32'h1E00_0040);
`else
        chk("t5_setwins_off", s_ea, 32'h0);
`endif

        // reset during a slave2 wait state
        step(32'h1F80_0000, NS, '1, '0, 1'b0);
        step(32'h0, ID, 4'b1011, '0, 1'b0);
        chk("t6_stall", 32'(s_hready), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_ready", 32'(bus.HREADY),    32'h1);
        chk("t6_resp",  32'(bus.HRESP),     32'h0);
        chk("t6_rdata", bus.HRDATA,         32'h0);
        chk("t6_errv",  32'(bus.ERR_VALID), 32'h0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;

        // random traffic
        for (int n = 0; n < 500; n++) begin
            a = $urandom;
            k = $urandom_range(0, 5);
            if (k < N) a = (a & ~MASK[k]) | BASE[k];
            else if (k == N) a = 32'h1E00_0000 | (a & 32'hE00F_FFFF);
            t = 2'($urandom_range(0, 3));
            for (int i = 0; i < N; i++) begin
                r[i]     = ($urandom_range(0, 3) != 0);
                p[i]     = ($urandom_range(0, 9) == 0);
                sdata[i] = $urandom;
            end
            c = ($urandom_range(0, 15) == 0);
            step(a, t, r, p, c);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
